// File: rtl/btn_debounce_if.sv
// Push-button debouncer signal bundle.
// master: the side that owns the raw pin and consumes the debounced results.
// slave:  the debouncer itself.
interface btn_debounce_if;
  logic btn_raw;
  logic btn_level;
  logic btn_press_pulse;
  logic btn_release_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press_pulse,
    input  btn_release_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press_pulse,
    output btn_release_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, polarity normalisation and a
// four-state qualify/hold FSM producing a debounced level plus press/release strobes.
// Optional build macro BTN_DEBOUNCE_AUTOREPEAT_EN adds REPEAT_DELAY/REPEAT_PERIOD
// auto-repeat of btn_press_pulse while the button stays pressed.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  btn_debounce_if.slave btn
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  localparam int unsigned     CntW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level that corresponds to "released".
  localparam logic            RelLevel = BTN_ACTIVE_LOW;

  logic [1:0]      sync_q;
  logic            pressed_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            rep_fire;

  // Synchronize the asynchronous pin; resets to the released level so reset looks idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q <= {2{RelLevel}};
    end else begin
      sync_q <= {sync_q[0], btn.btn_raw};
    end
  end

  assign pressed_s = BTN_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // Next-state logic: every wait state exits at CntMax, so the counter never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pressed_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!pressed_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!pressed_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (pressed_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntMax) begin
          state_d   = StIdle;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == StPressed) || (state_d == StReleaseWait);
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned     RepCycles   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
  localparam int unsigned     RepW        = $clog2(RepCycles);
  localparam logic [RepW-1:0] RepDelayMax = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPerMax   = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_armed_q, rep_armed_d;

  // Repeat timer runs only while staying in PRESSED; any other transition clears it.
  // rep_armed selects the initial delay versus the steady repeat period.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if ((state_q == StPressed) && (state_d == StPressed)) begin
      if (rep_cnt_q == (rep_armed_q ? RepPerMax : RepDelayMax)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RepW'(1);
      end
    end else begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d | rep_fire;
      release_q <= release_d;
    end
  end

  assign btn.btn_level         = level_q;
  assign btn.btn_press_pulse   = press_q;
  assign btn.btn_release_pulse = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES = 8, active-low button.
module tb_btn_debounce;
  localparam int Latency = 11;  // DEBOUNCE_CYCLES + 3

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  btn_debounce_if bus ();

  btn_debounce #(
    .DEBOUNCE_CYCLES(8),
    .BTN_ACTIVE_LOW (1'b1)
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
`endif
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .btn          (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] obs;
    rst_n       = 1'b0;
    bus.btn_raw = 1'b1;
    #2;
    obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outputs: got lvl/press/rel=%b expected 000", obs);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_release: got lvl/press/rel=%b expected 000", obs);
    end
  endtask

  task automatic test_idle_quiet;
    logic [2:0] obs;
    bus.btn_raw = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
      n_cmp++;
      if (obs !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_quiet edge %0d: got lvl/press/rel=%b expected 000", k, obs);
      end
    end
  endtask

  // Press and hold for n edges; edge k counted from the first sampling edge.
  task automatic test_press(input int n, input string tag);
    logic [2:0] obs;
    logic [2:0] exp;
    logic       exp_press;
    bus.btn_raw = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      exp_press = (k == Latency);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      if ((k >= Latency + 20) && (((k - Latency - 20) % 10) == 0)) exp_press = 1'b1;
`endif
      exp = {(k >= Latency), exp_press, 1'b0};
      obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s edge %0d: got lvl/press/rel=%b expected %b", tag, k, obs, exp);
      end
    end
  endtask

  task automatic test_release(input string tag);
    logic [2:0] obs;
    logic [2:0] exp;
    bus.btn_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp = {(k < Latency), 1'b0, (k == Latency)};
      obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s edge %0d: got lvl/press/rel=%b expected %b", tag, k, obs, exp);
      end
    end
  endtask

  // From released: short low bursts, then one burst of DEBOUNCE_CYCLES-1 samples.
  task automatic test_bounce_press;
    logic [2:0] obs;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 15; k++) begin
        if (r < 4) bus.btn_raw = (k < 5) ? 1'b0 : 1'b1;
        else       bus.btn_raw = (k < 7) ? 1'b0 : 1'b1;
        if ((r < 4) && (k >= 10)) break;
        tick();
        obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
        n_cmp++;
        if (obs !== 3'b000) begin
          n_bad++;
          $display("FAIL bounce_press burst %0d cycle %0d: got lvl/press/rel=%b expected 000",
                   r, k, obs);
        end
      end
    end
  endtask

  // From pressed: short high bursts must leave the level high with no strobes.
  task automatic test_bounce_release;
    logic [2:0] obs;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 15; k++) begin
        if (r < 4) bus.btn_raw = (k < 5) ? 1'b1 : 1'b0;
        else       bus.btn_raw = (k < 7) ? 1'b1 : 1'b0;
        if ((r < 4) && (k >= 10)) break;
        tick();
        obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
        n_cmp++;
        if (obs !== 3'b100) begin
          n_bad++;
          $display("FAIL bounce_release burst %0d cycle %0d: got lvl/press/rel=%b expected 100",
                   r, k, obs);
        end
      end
    end
  endtask

  // Reset while pressed: level drops at once, no release strobe, press re-qualified.
  task automatic test_reset_mid;
    logic [2:0] obs;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_async: got lvl/press/rel=%b expected 000", obs);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      obs = {bus.btn_level, bus.btn_press_pulse, bus.btn_release_pulse};
      n_cmp++;
      if (obs !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_hold edge %0d: got lvl/press/rel=%b expected 000", k, obs);
      end
    end
    rst_n = 1'b1;
    test_press(15, "reacquire");
  endtask

  initial begin
    test_reset();
    test_idle_quiet();
    test_press(15, "press");
    test_release("release");
    test_press(75, "hold");
    test_release("release_after_hold");
    test_bounce_press();
    test_press(15, "press_after_bounce");
    test_bounce_release();
    test_reset_mid();
    test_release("release_after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-sample count required to accept a level change (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter BTN_ACTIVE_LOW, default 1; 1 means btn_raw low = pressed, 0 means btn_raw high = pressed.
REQ-003 Port clk_clk  input  1  sole clock; all state on rising edge.
REQ-004 Port reset_reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port btn_raw  input  1  asynchronous, bouncing push-button pin.
REQ-006 Port btn_level  output  1  debounced level, 1 = pressed; drives the processor system's button PIO input.
REQ-007 Port btn_press_pulse  output  1  one-cycle strobe on accepted press.
REQ-008 Port btn_release_pulse  output  1  one-cycle strobe on accepted release.

Function
REQ-009 btn_raw SHALL pass through a 2-flop synchronizer, then be normalised to s (1 = pressed) per BTN_ACTIVE_LOW; no logic SHALL read btn_raw directly.
REQ-010 The FSM SHALL have four states: IDLE (released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE: s=1 -> PRESS_WAIT with counter cleared to 0; else stay.
REQ-012 PRESS_WAIT: s=0 -> IDLE (glitch rejected, no pulse); s=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter +1.
REQ-013 PRESSED: s=0 -> RELEASE_WAIT with counter cleared; else stay.
REQ-014 RELEASE_WAIT: s=1 -> PRESSED (no pulse); s=0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-015 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter SHALL never wrap, since every path exits at DEBOUNCE_CYCLES-1.
REQ-016 btn_level SHALL be registered and equal 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 Latency: with btn_raw held pressed from the first sampling edge, btn_level SHALL rise after rising edge DEBOUNCE_CYCLES+3 (edges 1-2 synchronize, edge 3 enters PRESS_WAIT, edge 3+DEBOUNCE_CYCLES enters PRESSED); release latency is identical.
REQ-018 btn_press_pulse SHALL be registered, high for exactly the one cycle following the PRESS_WAIT->PRESSED edge.
REQ-019 btn_release_pulse SHALL be registered, high for exactly the one cycle following the RELEASE_WAIT->IDLE edge.
REQ-020 btn_press_pulse and btn_release_pulse SHALL never be high in the same cycle.
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no change on any output.

Reset
REQ-022 reset_reset_n low SHALL asynchronously force state IDLE, counter 0, btn_level 0, both pulse outputs 0, and both synchronizer flops to the released level (1 if BTN_ACTIVE_LOW = 1, else 0).
REQ-023 Reset asserted mid-debounce or while PRESSED SHALL emit no release pulse. After deassertion, a button still held SHALL be re-qualified from IDLE per REQ-017.

Configuration
REQ-024 Macro BTN_DEBOUNCE_AUTOREPEAT_EN, when defined, SHALL add parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 5000000) plus a repeat counter active only in PRESSED.
REQ-025 With BTN_DEBOUNCE_AUTOREPEAT_EN defined: REPEAT_DELAY cycles after the initial press pulse, btn_press_pulse SHALL strobe again, then every REPEAT_PERIOD cycles while in PRESSED.
REQ-026 With BTN_DEBOUNCE_AUTOREPEAT_EN defined: the repeat counter SHALL clear on leaving PRESSED, on RELEASE_WAIT->PRESSED, and on reset.
REQ-027 Without BTN_DEBOUNCE_AUTOREPEAT_EN: a held button SHALL produce exactly one press pulse. The port list is identical in both builds.

Verification (DEBOUNCE_CYCLES = 8, BTN_ACTIVE_LOW = 1)
REQ-028 Reset released, btn_raw=1 for 50 cycles -> btn_level=0, no pulses.
REQ-029 btn_raw 1->0 held -> btn_level rises after edge 11; btn_press_pulse high for exactly that one cycle.
REQ-030 Bounce btn_raw 0 for 5 cycles, then 1, repeated 4 times -> no output change.
REQ-031 Held press, then btn_raw 0->1 held -> btn_level falls after edge 11 of release; btn_release_pulse high for one cycle.
REQ-032 Assert reset_reset_n=0 while PRESSED -> btn_level=0 immediately (asynchronously), no release pulse; deassert with button held -> press re-accepted after 11 edges.
REQ-033 With BTN_DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, hold 60 cycles after press -> pulses at press, +20, +30, +40, +50, +60.
